// File: rtl/sparse_sum_select_pipe_if.sv
// Handshake and payload bundle for the sparse sum-select stage.
// Upstream side : in_valid/in_ready, operand_1, operand_2, carry_in, block_carry
// Downstream side: out_valid/out_ready, sum, carry_out, overflow, carry_error
// The master modport is the traffic source/sink; the slave modport is the pipe.
interface sparse_sum_select_pipe_if #(
    parameter int unsigned N_BIT = 32
);
    localparam int unsigned NBLK = N_BIT / 4;

    logic             in_valid;
    logic             in_ready;
    logic [N_BIT-1:0] operand_1;
    logic [N_BIT-1:0] operand_2;
    logic             carry_in;
    logic [NBLK-1:0]  block_carry;
    logic             out_valid;
    logic             out_ready;
    logic [N_BIT-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             carry_error;

    modport master (
        output in_valid, operand_1, operand_2, carry_in, block_carry, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, carry_error
    );

    modport slave (
        input  in_valid, operand_1, operand_2, carry_in, block_carry, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, carry_error
    );
endinterface

// File: rtl/sparse_sum_select_pipe.sv
// Two-stage carry-select sum stage fed by a 4-sparse carry vector.
// Stage 1 registers both conditional 5-bit sums per nibble plus the select
// carries; stage 2 picks per nibble, and flags any nibble whose own carry-out
// disagrees with the supplied block carry.
// Ports: clk, rst (async, active-high), io (slave modport of
// sparse_sum_select_pipe_if: upstream valid/ready + operands, downstream
// valid/ready + sum, carry_out, overflow, carry_error).
module sparse_sum_select_pipe #(
    parameter int unsigned N_BIT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    sparse_sum_select_pipe_if.slave  io
);
    localparam int unsigned NBLK = N_BIT / 4;

    // Handshake
    logic s2_adv;
    logic s1_adv;
    logic accept;

    // Stage 1 state
    logic                  s1_valid_q, s1_valid_d;
    logic [NBLK-1:0][4:0]  s0_q, s0_d;
    logic [NBLK-1:0][4:0]  s1_q, s1_d;
    logic [NBLK-1:0]       sel_q, sel_d;
    logic [NBLK-1:0]       bc_q;
    logic                  msb1_q, msb2_q;

    // Stage 2 state
    logic                  out_valid_q, out_valid_d;
    logic [N_BIT-1:0]      sum_q, sum_d;
    logic                  carry_out_q;
    logic                  overflow_q, overflow_d;
    logic                  carry_error_q, carry_error_d;

    assign s2_adv      = ~out_valid_q | io.out_ready;
    assign s1_adv      = s1_valid_q & s2_adv;
    assign io.in_ready = ~s1_valid_q | s2_adv;
    assign accept      = io.in_valid & io.in_ready;

    // Stage 1 precompute: both conditional nibble sums and their select carries
    always_comb begin
        s0_d = '0;
        s1_d = '0;
        for (int unsigned j = 0; j < NBLK; j++) begin
            s0_d[j] = 5'(io.operand_1[4*j +: 4]) + 5'(io.operand_2[4*j +: 4]);
            s1_d[j] = s0_d[j] + 5'd1;
        end
        sel_d = {io.block_carry[NBLK-2:0], io.carry_in};
    end

    // Stage 1 holds its entry unless it is empty or draining this cycle
    assign s1_valid_d = io.in_ready ? accept : s1_valid_q;

    // Stage 2 select and consistency check
    always_comb begin
        logic [4:0] pick;
        pick          = '0;
        sum_d         = '0;
        carry_error_d = 1'b0;
        for (int unsigned j = 0; j < NBLK; j++) begin
            pick = sel_q[j] ? s1_q[j] : s0_q[j];
            sum_d[4*j +: 4] = pick[3:0];
            if (pick[4] != bc_q[j]) begin
                carry_error_d = 1'b1;
            end
        end
        overflow_d = (msb1_q == msb2_q) & (sum_d[N_BIT-1] != msb1_q);
    end

    // A fresh result takes priority over a consume in the same edge
    always_comb begin
        out_valid_d = out_valid_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s0_q       <= '0;
            s1_q       <= '0;
            sel_q      <= '0;
            bc_q       <= '0;
            msb1_q     <= 1'b0;
            msb2_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s0_q   <= s0_d;
                s1_q   <= s1_d;
                sel_q  <= sel_d;
                bc_q   <= io.block_carry;
                msb1_q <= io.operand_1[N_BIT-1];
                msb2_q <= io.operand_2[N_BIT-1];
            end
        end
    end

    // Stage 2 registers; payload only moves when stage 1 advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            sum_q         <= '0;
            carry_out_q   <= 1'b0;
            overflow_q    <= 1'b0;
            carry_error_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                sum_q         <= sum_d;
                carry_out_q   <= bc_q[NBLK-1];
                overflow_q    <= overflow_d;
                carry_error_q <= carry_error_d;
            end
        end
    end

    assign io.out_valid   = out_valid_q;
    assign io.sum         = sum_q;
    assign io.carry_out   = carry_out_q;
    assign io.overflow    = overflow_q;
    assign io.carry_error = carry_error_q;
endmodule
